// File: rtl/input_histogram.sv
// input_histogram
//   Upstream stage of the histogram-equalization pipeline. On start it clears
//   the 2^PIX_W-bin histogram in M2, then streams every source pixel from M1,
//   increments the matching M2 bin by read-modify-write and copies the pixel
//   unchanged into M3. done pulses for one cycle once the last bin update has
//   been written.
//
// Ports
//   clock            in   single rising-edge clock
//   reset_n          in   synchronous active-low reset
//   start            in   start request, honoured only in idle
//   M1_ReadBus       in   source pixel, valid one cycle after its address
//   M1_ReadAddress   out  source pixel address
//   M2_ReadBus       in   histogram bin read data (one-cycle latency)
//   M2_ReadAddress   out  histogram bin read address
//   M2_WriteBus      out  histogram bin write data
//   M2_WriteAddress  out  histogram bin write address
//   M2_WriteEnable   out  histogram write strobe
//   M3_WriteBus      out  pixel copy data
//   M3_WriteAddress  out  pixel copy address
//   M3_WriteEnable   out  pixel copy write strobe
//   done             out  one-cycle completion pulse
module input_histogram #(
  parameter int unsigned PIX_W      = 8,
  parameter int unsigned NUM_PIXELS = 1024,
  parameter int unsigned IMG_AW     = 10,
  parameter int unsigned CNT_W      = 11
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [PIX_W-1:0]  M1_ReadBus,
  output logic [IMG_AW-1:0] M1_ReadAddress,
  input  logic [CNT_W-1:0]  M2_ReadBus,
  output logic [PIX_W-1:0]  M2_ReadAddress,
  output logic [CNT_W-1:0]  M2_WriteBus,
  output logic [PIX_W-1:0]  M2_WriteAddress,
  output logic              M2_WriteEnable,
  output logic [PIX_W-1:0]  M3_WriteBus,
  output logic [IMG_AW-1:0] M3_WriteAddress,
  output logic              M3_WriteEnable,
  output logic              done
);

  // One index counter serves the clear sweep, the pixel sweep and the drain.
  localparam int unsigned IdxW = (IMG_AW > PIX_W) ? IMG_AW : PIX_W;
  localparam logic [IdxW-1:0] LastBin  = IdxW'((1 << PIX_W) - 1);
  localparam logic [IdxW-1:0] LastPix  = IdxW'(NUM_PIXELS - 1);
  localparam logic [IdxW-1:0] LastDrn  = IdxW'(1);

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StRun,
    StDrain,
    StDone
  } state_e;

  state_e            r_state, w_state_next;
  logic [IdxW-1:0]   r_idx, w_idx_next;

  // Stage 1: pixel data arriving from M1 for the address presented last cycle.
  logic              r_s1_valid;
  logic [IMG_AW-1:0] r_s1_addr;
  // Stage 2: bin read data arriving from M2, write back cnt+1.
  logic              r_s2_valid;
  logic [PIX_W-1:0]  r_s2_pix;
  // Last stage-2 write, kept for forwarding to a back-to-back equal pixel.
  logic              r_wb_valid;
  logic [PIX_W-1:0]  r_wb_bin;
  logic [CNT_W-1:0]  r_wb_data;

  logic              w_fwd;
  logic [CNT_W-1:0]  w_cnt;
  logic [CNT_W-1:0]  w_s2_data;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= StIdle;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_s1_valid <= 1'b0;
      r_s1_addr  <= '0;
      r_s2_valid <= 1'b0;
      r_s2_pix   <= '0;
      r_wb_valid <= 1'b0;
      r_wb_bin   <= '0;
      r_wb_data  <= '0;
    end else begin
      r_s1_valid <= (r_state == StRun);
      r_s1_addr  <= r_idx[IMG_AW-1:0];
      r_s2_valid <= r_s1_valid;
      r_s2_pix   <= M1_ReadBus;
      r_wb_valid <= r_s2_valid;
      r_wb_bin   <= r_s2_pix;
      r_wb_data  <= w_s2_data;
    end
  end

  // The M2 read for pixel i happens in the same cycle as the write for pixel
  // i-1, so the memory returns the stale count; take the in-flight value.
  assign w_fwd     = r_wb_valid && (r_wb_bin == r_s2_pix);
  assign w_cnt     = w_fwd ? r_wb_data : M2_ReadBus;
  assign w_s2_data = w_cnt + CNT_W'(1);

  always_comb begin
    w_state_next    = r_state;
    w_idx_next      = r_idx + IdxW'(1);
    M1_ReadAddress  = '0;
    M2_ReadAddress  = '0;
    M2_WriteBus     = '0;
    M2_WriteAddress = '0;
    M2_WriteEnable  = 1'b0;
    M3_WriteBus     = '0;
    M3_WriteAddress = '0;
    M3_WriteEnable  = 1'b0;
    done            = 1'b0;

    case (r_state)
      StIdle: begin
        w_idx_next = '0;
        if (start) begin
          w_state_next = StClear;
        end
      end
      StClear: begin
        M2_WriteEnable  = 1'b1;
        M2_WriteAddress = r_idx[PIX_W-1:0];
        if (r_idx == LastBin) begin
          w_state_next = StRun;
          w_idx_next   = '0;
        end
      end
      StRun: begin
        M1_ReadAddress = r_idx[IMG_AW-1:0];
        if (r_idx == LastPix) begin
          w_state_next = StDrain;
          w_idx_next   = '0;
        end
      end
      StDrain: begin
        if (r_idx == LastDrn) begin
          w_state_next = StDone;
          w_idx_next   = '0;
        end
      end
      StDone: begin
        done         = 1'b1;
        w_state_next = StIdle;
        w_idx_next   = '0;
      end
      default: begin
        w_state_next = StIdle;
        w_idx_next   = '0;
      end
    endcase

    if (r_s1_valid) begin
      M2_ReadAddress  = M1_ReadBus;
      M3_WriteEnable  = 1'b1;
      M3_WriteAddress = r_s1_addr;
      M3_WriteBus     = M1_ReadBus;
    end

    // Stage 2 never overlaps the clear sweep.
    if (r_s2_valid) begin
      M2_WriteEnable  = 1'b1;
      M2_WriteAddress = r_s2_pix;
      M2_WriteBus     = w_s2_data;
    end
  end

endmodule
